// File: rtl/wrr_sched_pkg.sv
// Shared types and helpers for the weighted round-robin packet scheduler.
package wrr_sched_pkg;

  typedef enum logic [0:0] {StArb, StXfer} state_e;

  // A zero weight still earns one packet per round so no stream starves.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/wrr_pkt_scheduler_if.sv
// Stream-side bundle of the scheduler: weights, per-stream inputs, merged output, status.
interface wrr_pkt_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned CWIDTH  = 3
);
  logic [NUM_REQ*CWIDTH-1:0]  weights;
  logic [NUM_REQ-1:0]         in_valid;
  logic [NUM_REQ-1:0]         in_ready;
  logic [NUM_REQ*DWIDTH-1:0]  in_data;
  logic [NUM_REQ-1:0]         in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [DWIDTH-1:0]          out_data;
  logic                       out_last;
  logic [$clog2(NUM_REQ)-1:0] out_sel;
  logic                       busy;

  modport master (
    output weights, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel, busy
  );

  modport slave (
    input  weights, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel, busy
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap-around.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_pkt_scheduler.sv
// Weighted round-robin packet scheduler: merges NUM_REQ beat streams, whole packets per grant,
// with per-stream credits reloaded from weights once no valid stream has credit left.
module wrr_pkt_scheduler
  import wrr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned CWIDTH  = 3
) (
  input logic                clk,
  input logic                rst_n,
  wrr_pkt_scheduler_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e                           state_q, state_d;
  logic [IdxW-1:0]                  ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CWIDTH-1:0]   credit_q, credit_d, credit_eff;
  logic                             out_valid_q, out_valid_d;
  logic                             out_last_q, out_last_d;
  logic [DWIDTH-1:0]                out_data_q, out_data_d;
  logic [IdxW-1:0]                  out_sel_q, out_sel_d;

  logic [NUM_REQ-1:0][DWIDTH-1:0]   in_data_arr;
  logic [NUM_REQ-1:0][CWIDTH-1:0]   weights_arr;
  logic [NUM_REQ-1:0]               has_credit, elig, pick_gnt, in_ready;
  logic [IdxW-1:0]                  pick_idx;
  logic                             new_round, out_free, accept;

  assign in_data_arr = bus.in_data;
  assign weights_arr = bus.weights;

  // A new round reloads all credits in the same cycle it is detected.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) has_credit[i] = (credit_q[i] != '0);
    new_round = ((bus.in_valid & has_credit) == '0) && (bus.in_valid != '0);
    for (int i = 0; i < NUM_REQ; i++) begin
      credit_eff[i] = new_round ? CWIDTH'(eff_weight(32'(weights_arr[i]))) : credit_q[i];
      elig[i]       = bus.in_valid[i] && (credit_eff[i] != '0);
    end
  end

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req_i(elig),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );

  assign out_free = !out_valid_q || bus.out_ready;

  always_comb begin
    in_ready = '0;
    if (state_q == StXfer) in_ready[ptr_q] = out_free;
  end

  assign accept = |(in_ready & bus.in_valid);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    unique case (state_q)
      StArb: begin
        if (|pick_gnt) begin
          state_d            = StXfer;
          ptr_d              = pick_idx;
          credit_d           = credit_eff;
          credit_d[pick_idx] = credit_eff[pick_idx] - CWIDTH'(1);
        end
      end
      StXfer: begin
        if (accept && bus.in_last[ptr_q]) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data_arr[ptr_q];
      out_last_d  = bus.in_last[ptr_q];
      out_sel_d   = ptr_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StArb;
      ptr_q       <= IdxW'(NUM_REQ - 1);
      credit_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.busy      = (state_q == StXfer);

endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
// Bench for wrr_pkt_scheduler: packet-level reference model checked every cycle,
// directed grant-order scenarios with literal expectations, then a randomized soak.
module tb_wrr_pkt_scheduler;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int CW = 3;
  localparam int WW = NR * CW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wrr_pkt_scheduler_if #(.NUM_REQ(NR), .DWIDTH(DW), .CWIDTH(CW)) bus ();

  wrr_pkt_scheduler #(
    .NUM_REQ(NR),
    .DWIDTH (DW),
    .CWIDTH (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total, bad;
  int cyc_cnt;

  // Reference model: granted stream (-1 when arbitrating), credits, last winner, output reg.
  int          m_gnt, m_last;
  int          m_cred[NR];
  logic        m_ov, m_ol;
  logic [DW-1:0] m_od;
  int          m_os;
  int          acc_pending;

  // Observed output handshakes.
  int          hs_sel[$];
  int          hs_cyc[$];
  logic [DW-1:0] hs_data[$];

  // Stimulus state per stream.
  int          s_beat[NR], s_len[NR], s_pkt[NR], s_lmin[NR], s_lmax[NR], s_prob[NR];
  logic [NR-1:0] s_en;
  int          or_mode;
  logic [DW-1:0] tmp_d;

  int e1[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int e2[12] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 0};
  int e3[6]  = '{2, 2, 2, 2, 2, 1};
  int e5[10] = '{0, 1, 1, 0, 1, 1, 0, 1, 0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc_cnt);
    end
  endtask

  function automatic int sel_at(input int i);
    return (i < hs_sel.size()) ? hs_sel[i] : 99;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : -100;
  endfunction

  function automatic logic [DW-1:0] dat_at(input int i);
    return (i < hs_data.size()) ? hs_data[i] : '1;
  endfunction

  task automatic chk_hs(input string nm, input int idx, input int req);
    chk(nm, 64'(sel_at(idx)), 64'(req));
  endtask

  function automatic logic [WW-1:0] wpack(input int w0, input int w1, input int w2, input int w3);
    return {CW'(w3), CW'(w2), CW'(w1), CW'(w0)};
  endfunction

  function automatic int new_len(input int i);
    return int'($urandom_range(s_lmax[i], s_lmin[i]));
  endfunction

  task automatic cfg(input logic [NR-1:0] en, input int prob, input int lmin, input int lmax);
    s_en = en;
    for (int i = 0; i < NR; i++) begin
      s_prob[i] = prob;
      s_lmin[i] = lmin;
      s_lmax[i] = lmax;
    end
  endtask

  task automatic model_reset();
    m_gnt  = -1;
    m_last = NR - 1;
    for (int i = 0; i < NR; i++) m_cred[i] = 0;
    m_ov = 1'b0;
    m_ol = 1'b0;
    m_od = '0;
    m_os = 0;
  endtask

  // Compare and model update, once per cycle on the falling edge.
  initial begin
    cyc_cnt = 0;
    acc_pending = -1;
    model_reset();
    forever begin
      logic [NR-1:0] exp_rdy;
      int  g;
      bit  any, found;
      @(negedge clk);
      cyc_cnt++;
      if (!rst_n) model_reset();
      exp_rdy = '0;
      if (m_gnt >= 0 && (!m_ov || bus.out_ready)) exp_rdy[m_gnt] = 1'b1;
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      chk("busy", 64'(bus.busy), 64'(m_gnt >= 0));
      chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
      chk("out_data", 64'(bus.out_data), 64'(m_od));
      chk("out_last", 64'(bus.out_last), 64'(m_ol));
      chk("out_sel", 64'(bus.out_sel), 64'(m_os));
      acc_pending = -1;
      if (rst_n) begin
        if (bus.out_valid && bus.out_ready) begin
          hs_sel.push_back(int'(bus.out_sel));
          hs_data.push_back(bus.out_data);
          hs_cyc.push_back(cyc_cnt);
        end
        if (m_gnt < 0) begin
          if (bus.out_ready) m_ov = 1'b0;
          if (bus.in_valid != '0) begin
            any = 1'b0;
            for (int i = 0; i < NR; i++) if (bus.in_valid[i] && m_cred[i] > 0) any = 1'b1;
            if (!any) begin
              for (int i = 0; i < NR; i++) begin
                m_cred[i] = int'(bus.weights[i*CW +: CW]);
                if (m_cred[i] == 0) m_cred[i] = 1;
              end
            end
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
              g = (m_last + k) % NR;
              if (!found && bus.in_valid[g] && m_cred[g] > 0) begin
                found     = 1'b1;
                m_cred[g] = m_cred[g] - 1;
                m_last    = g;
              end
            end
            m_gnt = m_last;
          end
        end else begin
          g = m_gnt;
          if (bus.in_valid[g] && (!m_ov || bus.out_ready)) begin
            acc_pending = g;
            m_ov = 1'b1;
            m_od = bus.in_data[g*DW +: DW];
            m_ol = bus.in_last[g];
            m_os = g;
            if (bus.in_last[g]) m_gnt = -1;
          end else if (bus.out_ready) begin
            m_ov = 1'b0;
          end
        end
      end
    end
  end

  // Stream sources: one packet at a time per stream, advancing on accepted beats.
  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (!rst_n) begin
          s_beat[i] = 0;
          s_pkt[i]  = 0;
          s_len[i]  = new_len(i);
        end else if (acc_pending == i) begin
          if (s_beat[i] == s_len[i] - 1) begin
            s_beat[i] = 0;
            s_pkt[i]++;
            s_len[i] = new_len(i);
          end else begin
            s_beat[i]++;
          end
        end
        bus.in_valid[i] = s_en[i] && (int'($urandom_range(99)) < s_prob[i]);
        bus.in_data[i*DW +: DW] = {8'(i), 8'(s_pkt[i]), 16'(s_beat[i])};
        bus.in_last[i] = (s_beat[i] == s_len[i] - 1);
      end
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = ($urandom_range(99) < 70);
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    hs_sel.delete();
    hs_data.delete();
    hs_cyc.delete();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_hs(input int n);
    int c = 0;
    while (hs_sel.size() < n && c < 500) begin
      @(posedge clk);
      c++;
    end
    if (hs_sel.size() < n) begin
      total++;
      bad++;
      $display("FAIL wait_hs: got %0d handshakes required %0d", hs_sel.size(), n);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    or_mode = 0;
    bus.weights = wpack(1, 1, 1, 1);
    cfg('0, 100, 1, 1);
    repeat (3) @(posedge clk);

    // Equal weights, 1-beat packets: strict rotation, one bubble between packets.
    cfg(4'hF, 100, 1, 1);
    bus.weights = wpack(1, 1, 1, 1);
    do_reset();
    wait_hs(8);
    foreach (e1[i]) chk_hs("p1_sel", i, e1[i]);
    for (int i = 1; i < 8; i++) chk("p1_gap", 64'(cyc_at(i) - cyc_at(i - 1)), 64'd2);

    // Stream 0 weighted 3: six grants per round, three to stream 0.
    bus.weights = wpack(3, 1, 1, 1);
    do_reset();
    wait_hs(12);
    foreach (e2[i]) chk_hs("p2_sel", i, e2[i]);

    // 5-beat packet on stream 2 with a stalling sink; stream 1 waits for last.
    cfg(4'b0100, 100, 1, 1);
    s_lmin[2] = 5;
    s_lmax[2] = 5;
    or_mode = 1;
    bus.weights = wpack(1, 1, 1, 1);
    do_reset();
    repeat (2) @(posedge clk);
    s_en = 4'b0110;
    wait_hs(6);
    foreach (e3[i]) chk_hs("p3_sel", i, e3[i]);
    for (int i = 0; i < 5; i++) begin
      tmp_d = dat_at(i);
      chk("p3_beat", 64'(tmp_d[15:0]), 64'(i));
      chk("p3_src", 64'(tmp_d[31:24]), 64'd2);
    end

    // Reset during the third beat of a 5-beat packet.
    cfg(4'hF, 100, 5, 5);
    or_mode = 0;
    do_reset();
    wait_hs(2);
    chk("p4_stream", 64'(cyc_at(1) - cyc_at(0)), 64'd1);
    #2;
    chk("p4_pre_busy", 64'(bus.busy), 64'd1);
    chk("p4_pre_valid", 64'(bus.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("p4_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("p4_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("p4_rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    hs_sel.delete();
    hs_data.delete();
    hs_cyc.delete();
    #2 rst_n = 1'b1;
    wait_hs(1);
    chk_hs("p4_first_sel", 0, 0);
    tmp_d = dat_at(0);
    chk("p4_first_beat", 64'(tmp_d[15:0]), 64'd0);

    // Zero weight served once per round; weights change applied at next reload only.
    cfg(4'b0011, 100, 1, 1);
    bus.weights = wpack(0, 2, 0, 0);
    do_reset();
    wait_hs(4);
    @(posedge clk);
    #2 bus.weights = wpack(3, 1, 0, 0);
    wait_hs(10);
    foreach (e5[i]) chk_hs("p5_sel", i, e5[i]);

    // Randomized soak against the model.
    cfg(4'hF, 60, 1, 4);
    or_mode = 2;
    bus.weights = WW'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (c % 250 == 0) begin
        #2;
        bus.weights = WW'($urandom);
        for (int i = 0; i < NR; i++) s_prob[i] = int'($urandom_range(100, 30));
      end
    end
    chk("rand_progress", 64'(hs_sel.size() > 100), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
